main_local_cluster: RTL and testbench
=====================================

// Module: main_local_cluster
// PURPOSE
//  Single-cluster convolution engine: 3x3 kernel over a 5x5 activation map, one
//  output row per start. Holds weight, activation and psum global buffers (GLBs)
//  written/read from the west port; loads GLB data into local scratchpads, then an
//  X_dim-column MAC array computes one output row, written back to the psum GLB.
// PARAMETERS
//  ADDR_BITWIDTH_GLB   6   GLB address width (depth 2**6 per GLB)
//  ADDR_BITWIDTH_SPAD  6   scratchpad address width
//  DATA_BITWIDTH       16  word width for iact, weight, psum
//  ADDR_BITWIDTH       6   external address port width
//  A_LOAD_ADDR/A_READ_ADDR 10  iact GLB write base / base copied to spad
//  W_LOAD_ADDR/W_READ_ADDR 0   weight GLB write base / base copied to spad
//  PSUM_READ_ADDR/PSUM_LOAD_ADDR 0  psum GLB read / write base
//  PSUM_ADDR           40  psum GLB size limit; write addresses >= PSUM_ADDR dropped
//  X_dim, Y_dim        3   MAC columns (outputs per row) / kernel rows per column
//  kernel_size 3, act_size 5  square kernel / activation edge
//  NUM_GLB_IACT/PSUM/WGHT 1  GLB banks per type (only 1 supported)
// PORTS
//  clk                        in  1   rising-edge clock
//  reset                      in  1   async, active-low reset
//  start                      in  1   begin one output-row computation
//  compute_done               out 1   level: row finished, psums written
//  load_done                  out 1   level: last GLB->spad load finished
//  write_en_iact/w_data_iact/w_addr_iact  in 1/16/6  iact GLB write port
//  west_enable_i_west_0_iact  in  1   load iact GLB->spad
//  write_en_wght/w_data_wght/w_addr_wght  in 1/16/6  weight GLB write port
//  west_enable_i_west_0_wght  in  1   load weight GLB->spad
//  west_0_req_read_psum       in  1   psum GLB read request
//  r_addr_psum                in  6   psum GLB read address
//  west_0_req_read_psum_inter in  1   live accumulator read request
//  r_addr_psum_inter          in  6   accumulator index (mod X_dim)
//  r_data_psum                out 16  read data
// BEHAVIOUR
//  - Reset (reset=0): all outputs 0, FSM IDLE, row index 0, accumulators 0; GLB
//    contents undefined. Reset mid-operation aborts immediately.
//  - GLB writes: synchronous, any state, when write_en_* high.
//  - FSM: IDLE, LOAD_W, LOAD_A, COMPUTE, WRITE. Inputs seen in IDLE only,
//    priority start > wght enable > iact enable; ignored in other states.
//  - LOAD_W: on enable in IDLE, clear load_done; copy wght GLB[W_READ_ADDR+i]
//    -> wspad[i], i=0..8, one word/cycle; after word 8 set load_done, IDLE.
//    LOAD_A same, 25 words from A_READ_ADDR. Dropping enable mid-load does not stop it.
//  - start in IDLE: clear compute_done, zero accumulators, enter COMPUTE (9 cycles).
//    Cycle k (kr=k/3, kc=k%3), each column c in parallel:
//    acc[c] += wspad[k]*aspad[(row+kr)*act_size + c+kc]; 16-bit wraps, unsigned.
//  - WRITE (1 cycle): psum GLB[PSUM_LOAD_ADDR + row*X_dim + c] = acc[c]; set
//    compute_done; row++ wrapping to 0 after act_size-kernel_size (=2); IDLE.
//    start-to-compute_done = 11 cycles. start held several cycles: one run.
//  - Reads: registered, 1-cycle latency. req_read_psum -> r_data_psum =
//    psumGLB[r_addr_psum]; else req_read_psum_inter -> acc[r_addr_psum_inter%X_dim];
//    else r_data_psum holds. Same-cycle write+read returns old data.
// STRUCTURE
//  - Shared package: FSM state enum, DATA/ADDR widths, KSQ=kernel_size**2,
//    ASQ=act_size**2, OUT_ROWS=act_size-kernel_size+1.
//  - One natural sub-module: mac_column (16-bit acc, clear/enable), X_dim
//    instances; GLBs/spads as inline register arrays.
// TESTING
//  - Weights all 1 at 0..8, iacts 1..25 at 10..34, both loads, start, read 0..2
//    -> 63,72,81.
//  - Second start, read 3..5 -> 108,117,126; third start, read 6..8 -> 153,162,171.
//  - load_done stays 1 after weight load until iact enable rises; compute_done
//    drops on start edge, returns 11 cycles later.
//  - start during COMPUTE or enable during LOAD_A ignored; results unchanged.
//  - reset low mid-COMPUTE -> outputs 0, FSM IDLE; fresh start computes row 0.
//  - Weight GLB = 2 -> row 0 reads 126,144,162 (16-bit overflow with large iacts wraps).

Source files
------------

// File: rtl/main_local_cluster_pkg.sv
// Shared definitions for the single-cluster convolution engine.
// Holds the widths, geometry, GLB base addresses, the control FSM state
// encoding and the common data/address types.
package main_local_cluster_pkg;

    localparam int ADDR_BITWIDTH_GLB  = 6;
    localparam int ADDR_BITWIDTH_SPAD = 6;
    localparam int DATA_BITWIDTH      = 16;
    localparam int ADDR_BITWIDTH      = 6;

    localparam int X_DIM       = 3;    // MAC columns, one output per column
    localparam int Y_DIM       = 3;    // kernel rows folded into each column
    localparam int KERNEL_SIZE = 3;
    localparam int ACT_SIZE    = 5;
    localparam int KSQ         = KERNEL_SIZE * KERNEL_SIZE;
    localparam int ASQ         = ACT_SIZE * ACT_SIZE;
    localparam int OUT_ROWS    = ACT_SIZE - KERNEL_SIZE + 1;
    localparam int GLB_DEPTH   = 2 ** ADDR_BITWIDTH_GLB;

    localparam logic [ADDR_BITWIDTH_GLB-1:0] A_READ_ADDR    = 6'd10;
    localparam logic [ADDR_BITWIDTH_GLB-1:0] W_READ_ADDR    = 6'd0;
    localparam logic [ADDR_BITWIDTH_GLB-1:0] PSUM_READ_ADDR = 6'd0;
    localparam logic [ADDR_BITWIDTH_GLB-1:0] PSUM_LOAD_ADDR = 6'd0;
    localparam logic [ADDR_BITWIDTH_GLB-1:0] PSUM_ADDR      = 6'd40;

    typedef logic [DATA_BITWIDTH-1:0]     data_t;
    typedef logic [ADDR_BITWIDTH_GLB-1:0] glb_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_A,
        ST_COMPUTE,
        ST_WRITE
    } state_e;

endpackage

// File: rtl/main_local_cluster_mac.sv
// mac_column: one multiply-accumulate column of the MAC array.
// Ports: clk, reset (async, active-low), clear (zero the accumulator),
//        enable (accumulate wght*iact), wght/iact operands, acc result.
// Arithmetic is unsigned and wraps at the data width.
module mac_column
    import main_local_cluster_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clear,
    input  logic  enable,
    input  data_t wght,
    input  data_t iact,
    output data_t acc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + wght * iact;
        end
    end

endmodule

// File: rtl/main_local_cluster.sv
// main_local_cluster: 3x3 kernel over a 5x5 activation map, one output row
// per start. Weight/iact GLBs are written from the west port, copied into
// local scratchpads on request, and an X_DIM-column MAC array produces one
// output row which is written into the psum GLB.
// Ports: clk, reset (async, active-low); start; compute_done/load_done status
// levels; iact and weight GLB write ports plus their load enables; psum GLB
// read request/address, live accumulator read request/index; r_data_psum.
module main_local_cluster
    import main_local_cluster_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     compute_done,
    output logic                     load_done,
    input  logic                     write_en_iact,
    input  logic [DATA_BITWIDTH-1:0] w_data_iact,
    input  logic [ADDR_BITWIDTH-1:0] w_addr_iact,
    input  logic                     west_enable_i_west_0_iact,
    input  logic                     write_en_wght,
    input  logic [DATA_BITWIDTH-1:0] w_data_wght,
    input  logic [ADDR_BITWIDTH-1:0] w_addr_wght,
    input  logic                     west_enable_i_west_0_wght,
    input  logic                     west_0_req_read_psum,
    input  logic [ADDR_BITWIDTH-1:0] r_addr_psum,
    input  logic                     west_0_req_read_psum_inter,
    input  logic [ADDR_BITWIDTH-1:0] r_addr_psum_inter,
    output logic [DATA_BITWIDTH-1:0] r_data_psum
);

    data_t wght_glb [GLB_DEPTH];
    data_t iact_glb [GLB_DEPTH];
    data_t psum_glb [GLB_DEPTH];
    data_t wspad    [KSQ];
    data_t aspad    [ASQ];

    state_e      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [1:0]  row_reg, row_next;
    logic        load_done_reg, load_done_next;
    logic        compute_done_reg, compute_done_next;
    logic        start_q_reg, wen_q_reg, aen_q_reg;

    logic        start_rise, wen_rise, aen_rise;
    logic        mac_clear, mac_en, psum_we, wspad_we, aspad_we;
    logic [4:0]  kr, kc;
    logic [1:0]  inter_sel;
    data_t       acc    [X_DIM];
    logic [4:0]  a_idx  [X_DIM];
    glb_addr_t   psum_waddr [X_DIM];

    // Control inputs act on their rising edge so a held start or enable
    // produces exactly one operation.
    assign start_rise = start & ~start_q_reg;
    assign wen_rise   = west_enable_i_west_0_wght & ~wen_q_reg;
    assign aen_rise   = west_enable_i_west_0_iact & ~aen_q_reg;

    assign kr = cnt_reg / 5'(KERNEL_SIZE);
    assign kc = cnt_reg % 5'(KERNEL_SIZE);

    assign compute_done = compute_done_reg;
    assign load_done    = load_done_reg;
    assign inter_sel    = 2'(r_addr_psum_inter % 6'(X_DIM));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            row_reg          <= '0;
            load_done_reg    <= 1'b0;
            compute_done_reg <= 1'b0;
            start_q_reg      <= 1'b0;
            wen_q_reg        <= 1'b0;
            aen_q_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            row_reg          <= row_next;
            load_done_reg    <= load_done_next;
            compute_done_reg <= compute_done_next;
            start_q_reg      <= start;
            wen_q_reg        <= west_enable_i_west_0_wght;
            aen_q_reg        <= west_enable_i_west_0_iact;
        end
    end

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        row_next          = row_reg;
        load_done_next    = load_done_reg;
        compute_done_next = compute_done_reg;
        mac_clear         = 1'b0;
        mac_en            = 1'b0;
        psum_we           = 1'b0;
        wspad_we          = 1'b0;
        aspad_we          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (start_rise) begin
                    compute_done_next = 1'b0;
                    mac_clear         = 1'b1;
                    state_next        = ST_COMPUTE;
                end else if (wen_rise) begin
                    load_done_next = 1'b0;
                    state_next     = ST_LOAD_W;
                end else if (aen_rise) begin
                    load_done_next = 1'b0;
                    state_next     = ST_LOAD_A;
                end
            end
            ST_LOAD_W: begin
                wspad_we = 1'b1;
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == 5'(KSQ - 1)) begin
                    load_done_next = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
            ST_LOAD_A: begin
                aspad_we = 1'b1;
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == 5'(ASQ - 1)) begin
                    load_done_next = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                mac_en   = 1'b1;
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == 5'(KSQ - 1)) begin
                    cnt_next   = '0;
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                psum_we           = 1'b1;
                compute_done_next = 1'b1;
                row_next          = (row_reg == 2'(OUT_ROWS - 1)) ? 2'd0 : row_reg + 2'd1;
                state_next        = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Column gi sees the activation window shifted gi positions to the right;
    // all columns share the same weight each cycle.
    generate
        for (genvar gi = 0; gi < X_DIM; gi++) begin : g_col
            assign a_idx[gi]      = 5'((int'(row_reg) + int'(kr)) * ACT_SIZE + gi + int'(kc));
            assign psum_waddr[gi] = PSUM_LOAD_ADDR + 6'(int'(row_reg) * X_DIM + gi);

            mac_column u_mac (
                .clk    (clk),
                .reset  (reset),
                .clear  (mac_clear),
                .enable (mac_en),
                .wght   (wspad[cnt_reg]),
                .iact   (aspad[a_idx[gi]]),
                .acc    (acc[gi])
            );
        end
    endgenerate

    // Storage arrays carry no reset; their contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (write_en_wght) begin
            wght_glb[w_addr_wght] <= w_data_wght;
        end
        if (write_en_iact) begin
            iact_glb[w_addr_iact] <= w_data_iact;
        end
        if (wspad_we) begin
            wspad[cnt_reg] <= wght_glb[W_READ_ADDR + 6'(cnt_reg)];
        end
        if (aspad_we) begin
            aspad[cnt_reg] <= iact_glb[A_READ_ADDR + 6'(cnt_reg)];
        end
        if (psum_we) begin
            for (int c = 0; c < X_DIM; c++) begin
                if (psum_waddr[c] < PSUM_ADDR) begin
                    psum_glb[psum_waddr[c]] <= acc[c];
                end
            end
        end
    end

    // Registered read port; a psum write in the same cycle is seen next read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_psum <= '0;
        end else if (west_0_req_read_psum) begin
            r_data_psum <= psum_glb[PSUM_READ_ADDR + r_addr_psum];
        end else if (west_0_req_read_psum_inter) begin
            r_data_psum <= acc[inter_sel];
        end
    end

endmodule

// File: tb/tb_main_local_cluster.sv
module tb_main_local_cluster;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        compute_done;
    logic        load_done;
    logic        write_en_iact;
    logic [15:0] w_data_iact;
    logic [5:0]  w_addr_iact;
    logic        west_enable_i_west_0_iact;
    logic        write_en_wght;
    logic [15:0] w_data_wght;
    logic [5:0]  w_addr_wght;
    logic        west_enable_i_west_0_wght;
    logic        west_0_req_read_psum;
    logic [5:0]  r_addr_psum;
    logic        west_0_req_read_psum_inter;
    logic [5:0]  r_addr_psum_inter;
    logic [15:0] r_data_psum;

    main_local_cluster dut (
        .clk                        (clk),
        .reset                      (reset),
        .start                      (start),
        .compute_done               (compute_done),
        .load_done                  (load_done),
        .write_en_iact              (write_en_iact),
        .w_data_iact                (w_data_iact),
        .w_addr_iact                (w_addr_iact),
        .west_enable_i_west_0_iact  (west_enable_i_west_0_iact),
        .write_en_wght              (write_en_wght),
        .w_data_wght                (w_data_wght),
        .w_addr_wght                (w_addr_wght),
        .west_enable_i_west_0_wght  (west_enable_i_west_0_wght),
        .west_0_req_read_psum       (west_0_req_read_psum),
        .r_addr_psum                (r_addr_psum),
        .west_0_req_read_psum_inter (west_0_req_read_psum_inter),
        .r_addr_psum_inter          (r_addr_psum_inter),
        .r_data_psum                (r_data_psum)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          inter;
        logic [5:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;

    typedef struct {
        string       name;
        logic [15:0] val;
    } sb_t;

    rd_vec_t vecs [18];
    sb_t     sb_q [$];
    int      n_vec  = 0;
    int      n_miss = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: got %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic glb_write(input bit is_w, input logic [5:0] addr, input logic [15:0] data);
        if (is_w) begin
            write_en_wght = 1'b1; w_addr_wght = addr; w_data_wght = data;
        end else begin
            write_en_iact = 1'b1; w_addr_iact = addr; w_data_iact = data;
        end
        tick();
        write_en_wght = 1'b0;
        write_en_iact = 1'b0;
    endtask

    // Read transaction: expectation queued on issue, compared when data appears.
    task automatic do_read(input bit inter, input logic [5:0] addr, input logic [15:0] exp);
        sb_t e;
        e.name = $sformatf("%s[%0d]", inter ? "acc" : "psum", addr);
        e.val  = exp;
        sb_q.push_back(e);
        if (inter) begin
            west_0_req_read_psum_inter = 1'b1; r_addr_psum_inter = addr;
        end else begin
            west_0_req_read_psum = 1'b1; r_addr_psum = addr;
        end
        tick();
        west_0_req_read_psum       = 1'b0;
        west_0_req_read_psum_inter = 1'b0;
        e = sb_q.pop_front();
        check(e.name, r_data_psum, e.val);
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            do_read(vecs[i].inter, vecs[i].addr, vecs[i].exp);
        end
    endtask

    // Load with the enable held two cycles; optional re-pulse mid-load.
    task automatic do_load(input bit is_w, input bit poke, input int exp_lat);
        int n;
        n = 0;
        if (is_w) west_enable_i_west_0_wght = 1'b1;
        else      west_enable_i_west_0_iact = 1'b1;
        while (n < 60) begin
            tick();
            n++;
            if (n == 1) check("load_done_cleared", 16'(load_done), 16'd0);
            if (n == 2) begin
                west_enable_i_west_0_wght = 1'b0;
                west_enable_i_west_0_iact = 1'b0;
            end
            if (poke && n == 5) begin
                if (is_w) west_enable_i_west_0_wght = 1'b1;
                else      west_enable_i_west_0_iact = 1'b1;
            end
            if (poke && n == 6) begin
                west_enable_i_west_0_wght = 1'b0;
                west_enable_i_west_0_iact = 1'b0;
            end
            if (load_done) break;
        end
        check(is_w ? "wload_latency" : "aload_latency", 16'(n), 16'(exp_lat));
    endtask

    // One row run: start held 3 cycles, optional start/iact-enable pokes mid-compute.
    task automatic run_row(input bit poke);
        int n;
        n = 0;
        start = 1'b1;
        while (n < 40) begin
            tick();
            n++;
            if (n == 1) check("compute_done_drop", 16'(compute_done), 16'd0);
            if (n == 3) start = 1'b0;
            if (poke && n == 5) begin start = 1'b1; west_enable_i_west_0_iact = 1'b1; end
            if (poke && n == 6) begin start = 1'b0; west_enable_i_west_0_iact = 1'b0; end
            if (compute_done) break;
        end
        start = 1'b0;
        check("done_latency", 16'(n), 16'd11);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 6'd0, 16'd63};
        vecs[1]  = '{1'b0, 6'd1, 16'd72};
        vecs[2]  = '{1'b0, 6'd2, 16'd81};
        vecs[3]  = '{1'b1, 6'd0, 16'd63};
        vecs[4]  = '{1'b1, 6'd4, 16'd72};
        vecs[5]  = '{1'b1, 6'd5, 16'd81};
        vecs[6]  = '{1'b0, 6'd3, 16'd108};
        vecs[7]  = '{1'b0, 6'd4, 16'd117};
        vecs[8]  = '{1'b0, 6'd5, 16'd126};
        vecs[9]  = '{1'b0, 6'd6, 16'd153};
        vecs[10] = '{1'b0, 6'd7, 16'd162};
        vecs[11] = '{1'b0, 6'd8, 16'd171};
        vecs[12] = '{1'b1, 6'd3, 16'd153};
        vecs[13] = '{1'b0, 6'd0, 16'd126};
        vecs[14] = '{1'b0, 6'd1, 16'd144};
        vecs[15] = '{1'b0, 6'd2, 16'd162};
        vecs[16] = '{1'b0, 6'd3, 16'd108};
        vecs[17] = '{1'b0, 6'd4, 16'd117};

        reset = 1'b0; start = 1'b0;
        write_en_iact = 1'b0; w_data_iact = '0; w_addr_iact = '0;
        write_en_wght = 1'b0; w_data_wght = '0; w_addr_wght = '0;
        west_enable_i_west_0_iact = 1'b0; west_enable_i_west_0_wght = 1'b0;
        west_0_req_read_psum = 1'b0; r_addr_psum = '0;
        west_0_req_read_psum_inter = 1'b0; r_addr_psum_inter = '0;

        repeat (3) tick();
        check("rst_r_data", r_data_psum, 16'd0);
        check("rst_compute_done", 16'(compute_done), 16'd0);
        check("rst_load_done", 16'(load_done), 16'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 9; i++)  glb_write(1'b1, 6'(i), 16'd1);
        for (int i = 0; i < 25; i++) glb_write(1'b0, 6'(10 + i), 16'(i + 1));

        do_load(1'b1, 1'b0, 10);
        repeat (3) tick();
        check("load_done_holds", 16'(load_done), 16'd1);
        do_load(1'b0, 1'b0, 26);

        run_row(1'b0);
        apply_vecs(0, 5);
        tick();
        check("r_data_holds", r_data_psum, 16'd81);

        run_row(1'b1);
        apply_vecs(6, 8);
        run_row(1'b0);
        apply_vecs(9, 12);

        // Row index wrapped; reload iacts with a mid-load re-pulse, recompute row 0.
        do_load(1'b0, 1'b1, 26);
        run_row(1'b0);
        apply_vecs(0, 2);

        for (int i = 0; i < 9; i++) glb_write(1'b1, 6'(i), 16'd2);
        do_load(1'b1, 1'b0, 10);

        // Abort row 1 mid-compute with reset.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("abort_compute_done", 16'(compute_done), 16'd0);
        check("abort_load_done", 16'(load_done), 16'd0);
        check("abort_r_data", r_data_psum, 16'd0);
        tick();
        reset = 1'b1;
        tick();
        do_read(1'b1, 6'd1, 16'd0);

        run_row(1'b0);
        apply_vecs(13, 17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
